rvv_backend_dispatch_credit_ctrl: RTL

Parametrised, credit-based dispatch controller for the RVV backend. It sits between the uop queue and the reservation stations (RS) and ROB. Each cycle it selects an in-order prefix of up to NUM_DP uops to push. It tracks free RS entries per execution unit and free ROB entries with internal credit counters, and it can debit the same unit more than once in a cycle, which a ready-per-slot scheme cannot do. It also provides a serial (single-issue) mode, flush recovery, a saturating stall counter and a sticky credit-overflow error.

---
 rtl/rvv_backend_dispatch_credit_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rvv_backend_dispatch_credit_ctrl.sv
// rtl/rvv_backend_dispatch_credit_ctrl.sv - credit-based in-order dispatch controller for the RVV backend
module rvv_backend_dispatch_credit_ctrl #(
    parameter  int NUM_DP    = 2,
    parameter  int NUM_UNIT  = 5,
    parameter  int RS_DEPTH  = 4,
    parameter  int ROB_DEPTH = 8,
    localparam int CW        = $clog2(RS_DEPTH + 1),
    localparam int RW        = $clog2(ROB_DEPTH + 1),
    localparam int NW        = $clog2(NUM_DP + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         serial_mode,
    input  logic [NUM_DP-1:0]            uop_valid,
    input  logic [NUM_DP-1:0]            uop_hazard,
    input  logic [NUM_DP*NUM_UNIT-1:0]   uop_unit,
    input  logic [NUM_DP-1:0]            uop_pshrob,
    output logic [NUM_DP-1:0]            uop_ready,
    output logic [NUM_DP*NUM_UNIT-1:0]   rs_valid,
    output logic [NUM_DP-1:0]            rob_valid,
    input  logic [NUM_UNIT*NW-1:0]       rs_ret,
    input  logic [NW-1:0]                rob_ret,
    output logic [NUM_UNIT*CW-1:0]       rs_credit,
    output logic [RW-1:0]                rob_credit,
    output logic [15:0]                  stall_cnt,
    output logic                         credit_err
);

    // Registered credit state, one counter per execution unit plus the ROB.
    logic [CW-1:0]       rs_cred_q [NUM_UNIT];
    logic [CW-1:0]       rs_cred_d [NUM_UNIT];
    logic [RW-1:0]       rob_cred_q;
    logic [RW-1:0]       rob_cred_d;
    logic                ovf;

    // Running demand per unit / ROB across slots, and the final debit totals.
    logic [31:0]         need_u   [NUM_UNIT];
    logic [31:0]         need_rob;
    logic [31:0]         disp_u   [NUM_UNIT];
    logic [31:0]         disp_rob;
    logic [NUM_UNIT-1:0] unit_sel;
    logic                rs_ok;
    logic                rob_ok;
    logic                slot_ok;
    logic                prefix;

    // Per-slot legality and in-order prefix selection; demand counts include every
    // earlier slot, so one unit can be debited several times in the same cycle.
    always_comb begin
        for (int u = 0; u < NUM_UNIT; u++) begin
            need_u[u] = '0;
            disp_u[u] = '0;
        end
        need_rob  = '0;
        disp_rob  = '0;
        unit_sel  = '0;
        rs_ok     = 1'b0;
        rob_ok    = 1'b0;
        slot_ok   = 1'b0;
        prefix    = 1'b1;
        uop_ready = '0;
        rs_valid  = '0;
        rob_valid = '0;
        for (int i = 0; i < NUM_DP; i++) begin
            unit_sel = uop_unit[i*NUM_UNIT +: NUM_UNIT];
            for (int u = 0; u < NUM_UNIT; u++) begin
                if (unit_sel[u]) begin
                    need_u[u] = need_u[u] + 32'd1;
                end
            end
            if (uop_pshrob[i]) begin
                need_rob = need_rob + 32'd1;
            end
            rs_ok = 1'b0;
            for (int u = 0; u < NUM_UNIT; u++) begin
                if (unit_sel[u] && (need_u[u] <= 32'(rs_cred_q[u]))) begin
                    rs_ok = 1'b1;
                end
            end
            rob_ok  = !uop_pshrob[i] || (need_rob <= 32'(rob_cred_q));
            slot_ok = uop_valid[i] && !uop_hazard[i] && $onehot(unit_sel) &&
                      rs_ok && rob_ok && !flush && ((i == 0) || !serial_mode);
            prefix  = prefix && slot_ok;
            uop_ready[i] = prefix;
            rs_valid[i*NUM_UNIT +: NUM_UNIT] = prefix ? unit_sel : '0;
            rob_valid[i] = prefix && uop_pshrob[i];
            for (int u = 0; u < NUM_UNIT; u++) begin
                if (prefix && unit_sel[u]) begin
                    disp_u[u] = disp_u[u] + 32'd1;
                end
            end
            if (prefix && uop_pshrob[i]) begin
                disp_rob = disp_rob + 32'd1;
            end
        end
    end

    // Next credit values: debit dispatches, add returns, clamp at depth and flag overflow.
    // Dispatch never exceeds the current credit, so the subtraction cannot wrap.
    always_comb begin
        logic [31:0] sum;
        ovf = 1'b0;
        sum = '0;
        for (int u = 0; u < NUM_UNIT; u++) begin
            sum = 32'(rs_cred_q[u]) - disp_u[u] + 32'(rs_ret[u*NW +: NW]);
            if (sum > 32'(RS_DEPTH)) begin
                rs_cred_d[u] = CW'(RS_DEPTH);
                ovf          = 1'b1;
            end else begin
                rs_cred_d[u] = CW'(sum);
            end
        end
        sum = 32'(rob_cred_q) - disp_rob + 32'(rob_ret);
        if (sum > 32'(ROB_DEPTH)) begin
            rob_cred_d = RW'(ROB_DEPTH);
            ovf        = 1'b1;
        end else begin
            rob_cred_d = RW'(sum);
        end
    end

    // Credit registers; flush restores full credit and discards same-cycle returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < NUM_UNIT; u++) begin
                rs_cred_q[u] <= CW'(RS_DEPTH);
            end
            rob_cred_q <= RW'(ROB_DEPTH);
        end else if (flush) begin
            for (int u = 0; u < NUM_UNIT; u++) begin
                rs_cred_q[u] <= CW'(RS_DEPTH);
            end
            rob_cred_q <= RW'(ROB_DEPTH);
        end else begin
            for (int u = 0; u < NUM_UNIT; u++) begin
                rs_cred_q[u] <= rs_cred_d[u];
            end
            rob_cred_q <= rob_cred_d;
        end
    end

    // Sticky overflow flag; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (!flush && ovf) begin
            credit_err <= 1'b1;
        end
    end

    // Saturating count of cycles where slot 0 had a uop but could not dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (uop_valid[0] && !uop_ready[0] && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Flatten the per-unit credit counters onto the output bus.
    always_comb begin
        rs_credit = '0;
        for (int u = 0; u < NUM_UNIT; u++) begin
            rs_credit[u*CW +: CW] = rs_cred_q[u];
        end
        rob_credit = rob_cred_q;
    end

endmodule
